// File: rtl/ne16_normquant_shifter.sv
// NE16 normquant shifter: bias add, arithmetic right shift, ReLU and 8/32-bit saturation.
// Optional rounding before the shift is built in when NE16_NQ_ROUNDING_EN is defined.

package ne16_package;
  localparam int NORM_MULT_SIZE  = 8;
  localparam int NE16_ACCUM_SIZE = 32;
endpackage

module ne16_normquant_shifter #(
  parameter int NMS  = ne16_package::NORM_MULT_SIZE,
  parameter int ACC  = ne16_package::NE16_ACCUM_SIZE,
  parameter int LENW = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [LENW-1:0]      len_i,
  input  logic [4:0]           shift_i,
  input  logic                 relu_i,
  input  logic                 mode32_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [NMS+ACC-1:0]   product_i,
  input  logic [ACC-1:0]       bias_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [31:0]          out_data_o,
  output logic                 out_last_o,
  output logic                 done_o
);

  localparam int PW = NMS + ACC;   // product width
  localparam int SW = PW + 1;      // bias-added sum width
  localparam int RW = PW + 2;      // room for the rounding constant

  localparam logic signed [RW-1:0] MAX32 = RW'(32'sh7FFF_FFFF);
  localparam logic signed [RW-1:0] MIN32 = ~MAX32;
  localparam logic signed [RW-1:0] MAX8  = RW'(127);
  localparam logic signed [RW-1:0] MIN8  = ~MAX8;
  localparam logic signed [RW-1:0] MAXU8 = RW'(255);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [LENW-1:0]       len_q, len_d;
  logic [4:0]            shift_q, shift_d;
  logic                  relu_q, relu_d;
  logic                  mode32_q, mode32_d;
  logic [LENW-1:0]       in_cnt_q, in_cnt_d;
  logic [LENW-1:0]       out_cnt_q, out_cnt_d;
  logic                  s1_v_q, s1_v_d;
  logic signed [SW-1:0]  s1_sum_q, s1_sum_d;
  logic                  s2_v_q, s2_v_d;
  logic [31:0]           s2_data_q, s2_data_d;
  logic                  done_q, done_d;

  logic                  s2_adv, s1_free, in_hs, out_hs, last_beat;
  logic signed [SW-1:0]  sum;
  logic signed [RW-1:0]  rnd, sh, lo_lim, hi_lim;
  logic [31:0]           quant;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sum = $signed({product_i[PW-1], product_i}) + $signed({{(SW-ACC){bias_i[ACC-1]}}, bias_i});
`ifdef NE16_NQ_ROUNDING_EN
    rnd = $signed({s1_sum_q[SW-1], s1_sum_q})
        + ((shift_q != 5'd0) ? (RW'(1) << (shift_q - 5'd1)) : RW'(0));
`else
    rnd = $signed({s1_sum_q[SW-1], s1_sum_q});
`endif
    sh = rnd >>> shift_q;

    // ReLU is folded into saturation: a zero lower bound clamps every negative result.
    if (mode32_q)    hi_lim = MAX32;
    else if (relu_q) hi_lim = MAXU8;
    else             hi_lim = MAX8;
    if (relu_q)        lo_lim = '0;
    else if (mode32_q) lo_lim = MIN32;
    else               lo_lim = MIN8;

    if (sh > hi_lim)      quant = hi_lim[31:0];
    else if (sh < lo_lim) quant = lo_lim[31:0];
    else                  quant = sh[31:0];
  end

  always_comb begin
    s2_adv      = ~s2_v_q | out_ready_i;
    s1_free     = ~s1_v_q | s2_adv;
    in_ready_o  = (state_q == RUN) & (in_cnt_q < len_q) & s1_free;
    in_hs       = in_valid_i & in_ready_o;
    out_hs      = s2_v_q & out_ready_i;
    last_beat   = (out_cnt_q == len_q - LENW'(1));
    out_valid_o = s2_v_q;
    out_data_o  = s2_data_q;
    out_last_o  = s2_v_q & last_beat;
    done_o      = done_q;

    state_d   = state_q;
    len_d     = len_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    mode32_d  = mode32_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    s1_v_d    = s1_v_q;
    s1_sum_d  = s1_sum_q;
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d   = RUN;
            len_d     = len_i;
            shift_d   = shift_i;
            relu_d    = relu_i;
            mode32_d  = mode32_i;
            in_cnt_d  = '0;
            out_cnt_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (in_hs)  in_cnt_d  = in_cnt_q + LENW'(1);
        if (out_hs) out_cnt_d = out_cnt_q + LENW'(1);
        if (out_hs && last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (s1_free) begin
      s1_v_d = in_hs;
      if (in_hs) s1_sum_d = sum;
    end
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) s2_data_d = quant;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q   <= IDLE;
      len_q     <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      mode32_q  <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      s1_v_q    <= 1'b0;
      s1_sum_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      mode32_q  <= mode32_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      s1_v_q    <= s1_v_d;
      s1_sum_q  <= s1_sum_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_ne16_normquant_shifter.sv
// Directed bench for ne16_normquant_shifter: stimulus pushes expected results into a
// scoreboard queue, an independent monitor pops and compares on every output handshake.

module tb_ne16_normquant_shifter;

`ifdef NE16_NQ_ROUNDING_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic        clk_i, rst_i, clear_i, start_i;
  logic [15:0] len_i;
  logic [4:0]  shift_i;
  logic        relu_i, mode32_i, in_valid_i, in_ready_o;
  logic [39:0] product_i;
  logic [31:0] bias_i;
  logic        out_valid_o, out_ready_i, out_last_o, done_o;
  logic [31:0] out_data_o;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  bit   t3_stop  = 1'b0;

  ne16_normquant_shifter dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .len_i(len_i), .shift_i(shift_i), .relu_i(relu_i), .mode32_i(mode32_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .product_i(product_i), .bias_i(bias_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_last_o(out_last_o), .done_o(done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: scoreboard compare on output handshakes, stall stability, done pulse count.
  initial begin : monitor
    logic        stall_prev;
    logic [31:0] held;
    exp_t        e;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (stall_prev) begin
          check1("stall_valid", out_valid_o, 1'b1);
          check("stall_data", out_data_o, held);
        end
        if (out_valid_o && out_ready_i) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got %h with no result pending", out_data_o);
          end else begin
            e = sb_q.pop_front();
            check("out_data", out_data_o, e.data);
            check1("out_last", out_last_o, e.last);
          end
        end
        if (done_o) done_cnt++;
      end
      stall_prev = out_valid_o && !out_ready_i && !clear_i && !rst_i;
      held       = out_data_o;
    end
  end

  task automatic start_job(input logic [15:0] len, input logic [4:0] sh,
                           input logic relu, input logic m32);
    tick();
    start_i  = 1'b1;
    len_i    = len;
    shift_i  = sh;
    relu_i   = relu;
    mode32_i = m32;
    tick();
    start_i  = 1'b0;
  endtask

  task automatic send_beat(input longint p, input int b, input logic [31:0] exp, input logic last);
    logic ok;
    exp_t e;
    ok         = 1'b0;
    product_i  = 40'(p);
    bias_i     = b;
    in_valid_i = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        e.data = exp;
        e.last = last;
        sb_q.push_back(e);
        ok = 1'b1;
      end
      tick();
    end
    in_valid_i = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: beat expecting %h never accepted", exp);
    end
  endtask

  task automatic wait_done(input int d0, input string nm);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 400) begin
      @(negedge clk_i);
      k++;
    end
    repeat (3) @(negedge clk_i);
    check(nm, 32'(done_cnt - d0), 32'd1);
    check({nm, "_drained"}, sb_q.size(), 0);
  endtask

  initial begin : stimulus
    int   d0;
    int   acc;
    logic [2:0] ph;
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; len_i = '0; shift_i = '0;
    relu_i = 1'b0; mode32_i = 1'b0; in_valid_i = 1'b0; product_i = '0; bias_i = '0;
    out_ready_i = 1'b0;
    repeat (3) tick();
    @(negedge clk_i);
    check1("rst_out_valid", out_valid_o, 1'b0);
    check1("rst_in_ready", in_ready_o, 1'b0);
    check("rst_out_data", out_data_o, 32'h0);
    check1("rst_out_last", out_last_o, 1'b0);
    check1("rst_done", done_o, 1'b0);
    tick();
    rst_i = 1'b0;

    // T1: single beat, latency and done timing. 1024 >>> 4 = 64 with or without rounding.
    out_ready_i = 1'b1;
    start_job(16'd1, 5'd4, 1'b0, 1'b1);
    product_i  = 40'd1000;
    bias_i     = 32'd24;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    check1("t1_in_ready", in_ready_o, 1'b1);
    sb_q.push_back({32'd64, 1'b1});
    tick();
    in_valid_i = 1'b0;
    @(negedge clk_i);
    check1("t1_lat1_invalid", out_valid_o, 1'b0);
    tick();
    @(negedge clk_i);
    check1("t1_lat2_valid", out_valid_o, 1'b1);
    check1("t1_last", out_last_o, 1'b1);
    tick();
    @(negedge clk_i);
    check1("t1_done", done_o, 1'b1);
    check1("t1_out_empty", out_valid_o, 1'b0);
    tick();
    @(negedge clk_i);
    check1("t1_done_once", done_o, 1'b0);
    check1("t1_idle_ready", in_ready_o, 1'b0);

    // Rounding: 1016/16 = 63.5, -1016/16 = -63.5.
    d0 = done_cnt;
    start_job(16'd2, 5'd4, 1'b0, 1'b1);
    send_beat(1000, 16, ROUND ? 32'd64 : 32'd63, 1'b0);
    send_beat(-1000, -16, ROUND ? 32'hFFFF_FFC1 : 32'hFFFF_FFC0, 1'b1);
    wait_done(d0, "round4_done");

    // Shift 31: -1 floors to -1, rounds to 0; 2^38 >>> 31 = 128.
    d0 = done_cnt;
    start_job(16'd2, 5'd31, 1'b0, 1'b1);
    send_beat(-1, 0, ROUND ? 32'h0 : 32'hFFFF_FFFF, 1'b0);
    send_beat(64'sh40_0000_0000, 0, 32'd128, 1'b1);
    wait_done(d0, "shift31_done");

    // T2: 8-bit signed saturation, shift 2.
    d0 = done_cnt;
    start_job(16'd5, 5'd2, 1'b0, 1'b0);
    send_beat(5000, 0, 32'h0000_007F, 1'b0);
    send_beat(-5000, 0, 32'hFFFF_FF80, 1'b0);
    send_beat(400, 0, 32'h0000_0064, 1'b0);
    send_beat(-403, 0, 32'hFFFF_FF9B, 1'b0);
    send_beat(406, 0, ROUND ? 32'h66 : 32'h65, 1'b1);
    wait_done(d0, "sat8_done");

    // T2: 8-bit ReLU range [0,255].
    d0 = done_cnt;
    start_job(16'd3, 5'd2, 1'b1, 1'b0);
    send_beat(-500, 0, 32'h0, 1'b0);
    send_beat(2000, 0, 32'h0000_00FF, 1'b0);
    send_beat(300, 0, 32'h0000_004B, 1'b1);
    wait_done(d0, "relu8_done");

    // 32-bit saturation and bias sign extension.
    d0 = done_cnt;
    start_job(16'd4, 5'd0, 1'b0, 1'b1);
    send_beat(64'sh40_0000_0000, 0, 32'h7FFF_FFFF, 1'b0);
    send_beat(-64'sh40_0000_0000, 0, 32'h8000_0000, 1'b0);
    send_beat(5, -12, 32'hFFFF_FFF9, 1'b0);
    send_beat(0, -1, 32'hFFFF_FFFF, 1'b1);
    wait_done(d0, "sat32_done");

    d0 = done_cnt;
    start_job(16'd2, 5'd0, 1'b1, 1'b1);
    send_beat(-7, 0, 32'h0, 1'b0);
    send_beat(64'sh40_0000_0000, 0, 32'h7FFF_FFFF, 1'b1);
    wait_done(d0, "relu32_done");

    // T3: backpressure. Fill both stages with the consumer stalled, then toggle out_ready_i.
    d0 = done_cnt;
    out_ready_i = 1'b0;
    start_job(16'd8, 5'd0, 1'b0, 1'b1);
    send_beat(7, 0, 32'h0000_0007, 1'b0);
    send_beat(-7, 0, 32'hFFFF_FFF9, 1'b0);
    product_i  = 40'd123456;
    bias_i     = 32'd1;
    in_valid_i = 1'b1;
    @(negedge clk_i);
    check1("t3_full_stall", in_ready_o, 1'b0);
    check1("t3_valid_held", out_valid_o, 1'b1);
    tick();
    @(negedge clk_i);
    check1("t3_full_stall2", in_ready_o, 1'b0);
    tick();
    fork
      begin
        ph = 3'd0;
        while (!t3_stop) begin
          out_ready_i = ph[0] ^ ph[1];
          ph = ph + 3'd1;
          tick();
        end
      end
    join_none
    send_beat(123456, 1, 32'h0001_E241, 1'b0);
    send_beat(-98765, 0, 32'hFFFE_7E33, 1'b0);
    send_beat(64'sh00_8000_0000, 0, 32'h7FFF_FFFF, 1'b0);
    send_beat(-5, -3, 32'hFFFF_FFF8, 1'b0);
    send_beat(1000, -1000, 32'h0, 1'b0);
    send_beat(0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(d0, "t3_done");
    t3_stop = 1'b1;
    tick();
    tick();
    out_ready_i = 1'b1;

    // T4: only len beats accepted even with in_valid_i held high.
    d0 = done_cnt;
    start_job(16'd3, 5'd0, 1'b0, 1'b1);
    acc = 0;
    in_valid_i = 1'b1;
    bias_i = '0;
    for (int i = 0; i < 6; i++) begin
      product_i = 40'(100 + i);
      @(negedge clk_i);
      if (in_ready_o) begin
        sb_q.push_back({32'(100 + i), acc == 2});
        acc++;
      end
      tick();
    end
    in_valid_i = 1'b0;
    check("t4_accepted", acc, 3);
    wait_done(d0, "t4_done");

    // T4: zero-length job pulses done once and never opens the input.
    d0 = done_cnt;
    start_job(16'd0, 5'd0, 1'b0, 1'b1);
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check1("t4_len0_no_ready", in_ready_o, 1'b0);
      tick();
    end
    in_valid_i = 1'b0;
    check("t4_len0_done", 32'(done_cnt - d0), 32'd1);

    // T5: clear mid-job with outputs stalled; clear beats a simultaneous start and input.
    d0 = done_cnt;
    start_job(16'd10, 5'd0, 1'b0, 1'b1);
    send_beat(11, 0, 32'd11, 1'b0);
    send_beat(22, 0, 32'd22, 1'b0);
    send_beat(33, 0, 32'd33, 1'b0);
    send_beat(44, 0, 32'd44, 1'b0);
    out_ready_i = 1'b0;
    tick();
    tick();
    clear_i    = 1'b1;
    start_i    = 1'b1;
    len_i      = 16'd2;
    in_valid_i = 1'b1;
    tick();
    clear_i    = 1'b0;
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    sb_q.delete();
    @(negedge clk_i);
    check1("t5_out_valid", out_valid_o, 1'b0);
    check1("t5_in_ready", in_ready_o, 1'b0);
    check1("t5_no_done", done_o, 1'b0);
    out_ready_i = 1'b1;
    repeat (4) tick();
    check("t5_no_done_later", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    start_job(16'd2, 5'd0, 1'b0, 1'b1);
    send_beat(-2, 0, 32'hFFFF_FFFE, 1'b0);
    send_beat(9, 0, 32'd9, 1'b1);
    wait_done(d0, "t5_restart_done");

    // T6: start_i during RUN is ignored (shift 4 / len 1 would change results and last).
    d0 = done_cnt;
    start_job(16'd3, 5'd0, 1'b0, 1'b1);
    start_i = 1'b1;
    len_i   = 16'd1;
    shift_i = 5'd4;
    tick();
    start_i = 1'b0;
    send_beat(1600, 0, 32'h0000_0640, 1'b0);
    send_beat(-32, 0, 32'hFFFF_FFE0, 1'b0);
    send_beat(5, 5, 32'h0000_000A, 1'b1);
    wait_done(d0, "t6_ignore_start_done");

    // T6: synchronous reset during streaming.
    d0 = done_cnt;
    start_job(16'd5, 5'd0, 1'b0, 1'b1);
    out_ready_i = 1'b0;
    send_beat(77, 0, 32'd77, 1'b0);
    send_beat(88, 0, 32'd88, 1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    sb_q.delete();
    @(negedge clk_i);
    check1("t6_out_valid", out_valid_o, 1'b0);
    check1("t6_in_ready", in_ready_o, 1'b0);
    check("t6_out_data", out_data_o, 32'h0);
    check1("t6_out_last", out_last_o, 1'b0);
    check1("t6_done", done_o, 1'b0);
    out_ready_i = 1'b1;
    repeat (3) tick();
    check("t6_no_done", 32'(done_cnt - d0), 32'd0);
    check("final_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
